// File: rtl/port_ingress_buffer.sv
// Per-port ingress buffer: stores whole framed packets, advertises ready plus the
// head packet's priority once a packet is complete, and plays it out word by word.
// Packets are written speculatively and published atomically on their last word;
// a packet that cannot fit, or is cut short by a new sop, is discarded with a drop pulse.
// The head-priority output is named priority_o because "priority" is a reserved word.
module port_ingress_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int PKT_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_vld,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [2:0]            wr_prio,
  input  logic                  rd_en,
  output logic                  ready,
  output logic [2:0]            priority_o,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  eop,
  output logic                  drop
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = $clog2(PKT_DEPTH);
  localparam int PTRW = AW + 1;
  localparam int PKTW = PW + 1;
  localparam logic [PTRW-1:0] DEPTH_W = PTRW'(DEPTH);
  localparam logic [PKTW-1:0] PKT_W   = PKTW'(PKT_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} wstate_t;

  // Storage: data word plus a last-of-packet flag, and one priority per committed packet.
  logic [DATA_WIDTH:0] mem_q  [DEPTH];
  logic [2:0]          desc_q [PKT_DEPTH];

  wstate_t             state_q, state_d;
  logic [PTRW-1:0]     wp_s_q, wp_s_d;   // speculative write pointer
  logic [PTRW-1:0]     wp_c_q, wp_c_d;   // committed write pointer
  logic [PTRW-1:0]     rp_q, rp_d;
  logic [PKTW-1:0]     dwp_q, dwp_d;
  logic [PKTW-1:0]     drp_q, drp_d;
  logic [2:0]          prio_q, prio_d;   // priority of the packet being received
  logic                ready_q, ready_d;
  logic [2:0]          head_q, head_d;
  logic                rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                eop_q;
  logic                drop_q, drop_d;

  logic                mem_we;
  logic [PTRW-1:0]     base;             // where a new packet's first word lands
  logic                start;
  logic                push;
  logic [2:0]          push_prio;
  logic                desc_full;
  logic                rd_fire;
  logic [DATA_WIDTH:0] rd_word;
  logic                pop;
  logic [PKTW-1:0]     cnt_d;

  assign desc_full = ((dwp_q - drp_q) == PKT_W);

  // Write FSM: decides what happens to the incoming word and where the pointers go.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    wp_s_d    = wp_s_q;
    wp_c_d    = wp_c_q;
    prio_d    = prio_q;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    push      = 1'b0;
    push_prio = prio_q;
    start     = 1'b0;
    base      = wp_s_q;

    unique case (state_q)
      S_IDLE: if (wr_vld && wr_sop) start = 1'b1;
      S_RECV: if (wr_vld) begin
        if (wr_sop) begin
          // Previous packet never saw its eop: throw it away and restart here.
          drop_d = 1'b1;
          wp_s_d = wp_c_q;
          base   = wp_c_q;
          start  = 1'b1;
        end else if ((wp_s_q - rp_q) == DEPTH_W) begin
          drop_d  = 1'b1;
          wp_s_d  = wp_c_q;
          state_d = wr_eop ? S_IDLE : S_DROP;
        end else begin
          mem_we = 1'b1;
          wp_s_d = wp_s_q + 1'b1;
          if (wr_eop) begin
            wp_c_d  = wp_s_q + 1'b1;
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: if (wr_vld) begin
        if (wr_sop && !wr_eop) start   = 1'b1;
        else if (wr_eop)       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Start of a packet, shared by every state that can accept a sop.
    if (start) begin
      if (desc_full || ((base - rp_q) == DEPTH_W)) begin
        drop_d  = 1'b1;
        state_d = wr_eop ? S_IDLE : S_DROP;
      end else begin
        mem_we = 1'b1;
        wp_s_d = base + 1'b1;
        prio_d = wr_prio;
        if (wr_eop) begin
          wp_c_d    = base + 1'b1;
          push      = 1'b1;
          push_prio = wr_prio;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RECV;
        end
      end
    end
  end

  // Read side and next head-of-queue view; commits become visible one cycle later.
  always_comb begin
    rd_fire = rd_en && (rp_q != wp_c_q);
    rd_word = mem_q[rp_q[AW-1:0]];
    pop     = rd_fire && rd_word[DATA_WIDTH];
    rp_d    = rp_q + PTRW'(rd_fire);
    drp_d   = drp_q + PKTW'(pop);
    dwp_d   = dwp_q + PKTW'(push);
    cnt_d   = dwp_d - drp_d;
    ready_d = (cnt_d != '0);
    head_d  = '0;
    if (ready_d) begin
      // A priority pushed this cycle into an otherwise empty queue is not in desc_q yet.
      if (push && (dwp_q == drp_d)) head_d = push_prio;
      else                          head_d = desc_q[drp_d[PW-1:0]];
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst) begin
      state_q   <= S_IDLE;
      wp_s_q    <= '0;
      wp_c_q    <= '0;
      rp_q      <= '0;
      dwp_q     <= '0;
      drp_q     <= '0;
      prio_q    <= '0;
      ready_q   <= 1'b0;
      head_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      eop_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wp_s_q   <= wp_s_d;
      wp_c_q   <= wp_c_d;
      rp_q     <= rp_d;
      dwp_q    <= dwp_d;
      drp_q    <= drp_d;
      prio_q   <= prio_d;
      ready_q  <= ready_d;
      head_q   <= head_d;
      rd_vld_q <= rd_fire;
      eop_q    <= pop;
      drop_q   <= drop_d;
      if (rd_fire) rd_data_q <= rd_word[DATA_WIDTH-1:0];
    end
  end

  // Storage arrays.
  always_ff @(posedge clk) begin
    // NOTE: arrays are not reset; pointers define which entries are meaningful.
    if (mem_we) mem_q[base[AW-1:0]]   <= {wr_eop, wr_data};
    if (push)   desc_q[dwp_q[PW-1:0]] <= push_prio;
  end

  assign ready      = ready_q;
  assign priority_o = head_q;
  assign rd_vld     = rd_vld_q;
  assign rd_data    = rd_data_q;
  assign eop        = eop_q;
  assign drop       = drop_q;

endmodule

// File: tb/tb_port_ingress_buffer.sv
// Bench for port_ingress_buffer: directed scenarios followed by random traffic,
// every cycle compared against a packet-level queue model.
module tb_port_ingress_buffer;

  localparam int DW        = 32;
  localparam int DEPTH     = 64;
  localparam int PKT_DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_vld = 1'b0, wr_sop = 1'b0, wr_eop = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [2:0]    wr_prio = '0;
  logic          ready, rd_vld, eop, drop;
  logic [2:0]    prio_out;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  port_ingress_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_DEPTH(PKT_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_vld(wr_vld), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_data(wr_data), .wr_prio(wr_prio),
    .rd_en(rd_en),
    .ready(ready), .priority_o(prio_out), .rd_vld(rd_vld), .rd_data(rd_data),
    .eop(eop), .drop(drop)
  );

  int total = 0;
  int bad   = 0;
  int drop_seen = 0;
  int eop_seen  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: committed words awaiting read, one priority per unread packet,
  // and the words of the packet currently arriving.
  typedef struct packed { logic last; logic [DW-1:0] data; } word_t;
  typedef enum {M_IDLE, M_RECV, M_DROP} mode_t;

  word_t         words_q[$];
  logic [2:0]    prios_q[$];
  logic [DW-1:0] part_q[$];
  mode_t         mode = M_IDLE;
  logic [2:0]    cur_prio = '0;

  logic          e_ready = 1'b0, e_rd_vld = 1'b0, e_eop = 1'b0, e_drop = 1'b0;
  logic [2:0]    e_prio = '0;
  logic [DW-1:0] e_data = '0;

  function automatic void m_commit();
    word_t w;
    foreach (part_q[i]) begin
      w.last = (i == part_q.size() - 1);
      w.data = part_q[i];
      words_q.push_back(w);
    end
    prios_q.push_back(cur_prio);
    part_q.delete();
    mode = M_IDLE;
  endfunction

  function automatic void m_start(input int committed_words, input int pkts);
    part_q.delete();
    if (pkts == PKT_DEPTH || committed_words == DEPTH) begin
      e_drop = 1'b1;
      mode   = wr_eop ? M_IDLE : M_DROP;
    end else begin
      part_q.push_back(wr_data);
      cur_prio = wr_prio;
      if (wr_eop) m_commit();
      else        mode = M_RECV;
    end
  endfunction

  function automatic void m_step();
    int    cw;
    int    pk;
    bit    can_rd;
    word_t w;
    cw     = words_q.size();
    pk     = prios_q.size();
    can_rd = (cw > 0);
    e_drop   = 1'b0;
    e_rd_vld = 1'b0;
    e_eop    = 1'b0;
    if (!rst) begin
      words_q.delete(); prios_q.delete(); part_q.delete();
      mode = M_IDLE; e_data = '0; e_ready = 1'b0; e_prio = '0;
      return;
    end
    if (wr_vld) begin
      case (mode)
        M_IDLE: if (wr_sop) m_start(cw, pk);
        M_RECV: begin
          if (wr_sop) begin
            e_drop = 1'b1;
            m_start(cw, pk);
          end else if (cw + part_q.size() == DEPTH) begin
            e_drop = 1'b1;
            part_q.delete();
            mode = wr_eop ? M_IDLE : M_DROP;
          end else begin
            part_q.push_back(wr_data);
            if (wr_eop) m_commit();
          end
        end
        M_DROP: begin
          if (wr_sop && !wr_eop) m_start(cw, pk);
          else if (wr_eop)       mode = M_IDLE;
        end
        default: ;
      endcase
    end
    if (rd_en && can_rd) begin
      w        = words_q.pop_front();
      e_rd_vld = 1'b1;
      e_data   = w.data;
      e_eop    = w.last;
      if (w.last) void'(prios_q.pop_front());
    end
    e_ready = (prios_q.size() != 0);
    e_prio  = e_ready ? prios_q[0] : 3'd0;
  endfunction

  // One clock: model consumes the inputs present at the edge, outputs are checked 1 after.
  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    check("ready", ready, e_ready);
    check("priority", prio_out, e_prio);
    check("rd_vld", rd_vld, e_rd_vld);
    check("eop", eop, e_eop);
    check("drop", drop, e_drop);
    if (e_rd_vld) check("rd_data", rd_data, e_data);
    drop_seen += int'(drop);
    eop_seen  += int'(eop);
  endtask

  task automatic send(input int n, input int prio, input bit omit_eop);
    for (int i = 0; i < n; i++) begin
      wr_vld  = 1'b1;
      wr_sop  = (i == 0);
      wr_eop  = (i == n - 1) && !omit_eop;
      wr_prio = 3'(prio);
      wr_data = $urandom;
      cyc();
    end
    wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
  endtask

  task automatic idle(input int n, input bit rd);
    rd_en = rd;
    repeat (n) cyc();
    rd_en = 1'b0;
  endtask

  int rd_pct;

  initial begin
    // Reset held two cycles.
    rst = 1'b0;
    cyc(); cyc();
    check("rst_rd_data", rd_data, '0);
    rst = 1'b1;
    cyc();

    // One 4-word packet, priority 5, then four reads.
    send(4, 5, 1'b0);
    check("p4_ready", ready, 1'b1);
    check("p4_prio", prio_out, 3'd5);
    idle(4, 1'b1);
    idle(2, 1'b0);

    // Two packets back to back: 1 word prio 2, 3 words prio 7.
    send(1, 2, 1'b0);
    send(3, 7, 1'b0);
    idle(1, 1'b0);
    idle(5, 1'b1);
    idle(2, 1'b0);

    // Fill: 40-word packet fits, 30-word packet overflows on its 25th word.
    drop_seen = 0;
    send(40, 1, 1'b0);
    send(30, 3, 1'b0);
    idle(1, 1'b0);
    check("fill_drops", drop_seen, 1);
    check("fill_ready", ready, 1'b1);
    eop_seen = 0;
    idle(42, 1'b1);
    check("fill_eops", eop_seen, 1);
    check("fill_empty", ready, 1'b0);

    // Missing eop: partial packet abandoned by a new 1-word packet.
    drop_seen = 0;
    send(2, 4, 1'b1);
    send(1, 6, 1'b0);
    idle(1, 1'b0);
    check("noeop_drops", drop_seen, 1);
    eop_seen = 0;
    idle(3, 1'b1);
    check("noeop_eops", eop_seen, 1);

    // Nine 1-word packets into an 8-entry descriptor queue.
    drop_seen = 0;
    for (int i = 0; i < 9; i++) send(1, i % 8, 1'b0);
    idle(1, 1'b0);
    check("nine_drops", drop_seen, 1);
    eop_seen = 0;
    idle(10, 1'b1);
    check("nine_eops", eop_seen, 8);
    check("nine_ready", ready, 1'b0);

    // Random framing, reads and occasional resets; read rate varies per segment.
    for (int seg = 0; seg < 8; seg++) begin
      rd_pct = (seg % 4) * 20 + 5;
      for (int c = 0; c < 500; c++) begin
        rst     = ($urandom_range(399) != 0);
        wr_vld  = ($urandom_range(3) != 0);
        wr_sop  = ($urandom_range(7) == 0);
        wr_eop  = ($urandom_range(5) == 0);
        wr_prio = 3'($urandom);
        wr_data = $urandom;
        rd_en   = ($urandom_range(99) < rd_pct);
        cyc();
      end
    end
    rst = 1'b1; wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; rd_en = 1'b0;
    idle(2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
